// File: rtl/clk_div_pkg.sv
// Shared constants and ratio helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int DIV_MIN = 2;
  localparam int CALC_W  = 32;

  function automatic logic [CALC_W-1:0] half_f(input logic [CALC_W-1:0] d);
    return d >> 1;
  endfunction

  function automatic logic is_odd_f(input logic [CALC_W-1:0] d);
    return (d & CALC_W'(1)) != '0;
  endfunction

endpackage

// File: rtl/clk_div_halfext.sv
// Negedge half-cycle extender: stretches the high phase by half a source clock
// for odd ratios so the divided clock keeps a 50% duty cycle.
module clk_div_halfext (
  input  logic clk,
  input  logic rst_n,
  input  logic odd_i,
  input  logic clk_p_i,
  output logic clk_out
);

  logic clk_n_q;

  // Gated by parity so a ratio change from even to odd can never inherit a stale high half-cycle.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      clk_n_q <= 1'b0;
    end else begin
      clk_n_q <= clk_p_i & odd_i;
    end
  end

  assign clk_out = odd_i ? (clk_p_i | clk_n_q) : clk_p_i;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty, glitch-free ratio
// changes at period boundaries, and a source-domain tick on each rising edge.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DIV_DEFAULT = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             load_i,
  output logic             load_ack_o,
  output logic             err_o,
  output logic             clk_out,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] d_cur_q, d_cur_d;
  logic [DIV_W-1:0] d_pend_q, d_pend_d;
  logic             pend_q, pend_d;
  logic             clk_p_q, clk_p_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic             active;
  logic             boundary;
  logic             load_ok;
  logic             pend_any;
  logic [DIV_W-1:0] pend_val;
  logic             apply;

  // A started period always runs to its boundary; idle means cnt parked at 0 with en_i low.
  always_comb begin
    active   = en_i || (cnt_q != '0);
    boundary = active && (cnt_q == d_cur_q - DIV_W'(1));
    load_ok  = load_i && (div_i >= DIV_W'(DIV_MIN));
    pend_any = load_ok || pend_q;
    pend_val = load_ok ? div_i : d_pend_q;
    apply    = pend_any && (boundary || !active);

    cnt_d    = '0;
    if (active && !boundary) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    clk_p_d  = active && (CALC_W'(cnt_q) < half_f(CALC_W'(d_cur_q)));
    tick_d   = active && (cnt_q == '0);
    d_cur_d  = apply ? pend_val : d_cur_q;
    d_pend_d = pend_val;
    pend_d   = pend_any && !apply;
    ack_d    = apply;
    err_d    = load_i && !load_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      d_cur_q  <= DIV_W'(DIV_DEFAULT);
      d_pend_q <= DIV_W'(DIV_DEFAULT);
      pend_q   <= 1'b0;
      clk_p_q  <= 1'b0;
      tick_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      d_cur_q  <= d_cur_d;
      d_pend_q <= d_pend_d;
      pend_q   <= pend_d;
      clk_p_q  <= clk_p_d;
      tick_q   <= tick_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  clk_div_halfext u_halfext (
    .clk     (clk),
    .rst_n   (rst_n),
    .odd_i   (is_odd_f(CALC_W'(d_cur_q))),
    .clk_p_i (clk_p_q),
    .clk_out (clk_out)
  );

  assign tick_o     = tick_q;
  assign load_ack_o = ack_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios plus random traffic,
// compared against a half-cycle level model of the divided clock.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rstN;
  logic       enI;
  logic       loadI;
  logic [7:0] divI;
  logic       loadAck;
  logic       err;
  logic       clkOut;
  logic       tick;

  int checks = 0;
  int errors = 0;

  // Model: current ratio, pending ratio, cycles left in the running period,
  // and half-cycles of high level still owed to clk_out.
  int   mD     = 7;
  int   mPv    = 7;
  int   mLeft  = 0;
  int   mHi    = 0;
  logic mPend  = 1'b0;
  logic expTick, expAck, expErr, skipHigh;

  clk_div_prog #(.DIV_W(8), .DIV_DEFAULT(7)) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .en_i       (enI),
    .div_i      (divI),
    .load_i     (loadI),
    .load_ack_o (loadAck),
    .err_o      (err),
    .clk_out    (clkOut),
    .tick_o     (tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  function automatic int nextCnt();
    return (mLeft == 0) ? 0 : mD - mLeft;
  endfunction

  task automatic applyStimulus(input logic en, input logic ld, input logic [7:0] dv, input logic rn);
    enI   = en;
    loadI = ld;
    divI  = dv;
    rstN  = rn;
    @(posedge clk);
    expTick  = 1'b0;
    expAck   = 1'b0;
    expErr   = 1'b0;
    skipHigh = 1'b0;
    if (!rn) begin
      mD = 7; mPend = 1'b0; mLeft = 0; mHi = 0; skipHigh = 1'b1;
    end else begin
      if (ld && dv < 2) expErr = 1'b1;
      if (ld && dv >= 2) begin mPend = 1'b1; mPv = int'(dv); end
      if (mLeft > 0) begin
        mLeft--;
        mHi = (mHi > 2) ? mHi - 2 : 0;
        if (mLeft == 0 && mPend) begin mD = mPv; mPend = 1'b0; expAck = 1'b1; end
      end else if (en) begin
        mHi = mD; mLeft = mD - 1; expTick = 1'b1;
      end else begin
        mHi = 0;
        if (mPend) begin mD = mPv; mPend = 1'b0; expAck = 1'b1; end
      end
    end
    #1;
    checkOutput("tick_o", tick, expTick);
    checkOutput("load_ack_o", loadAck, expAck);
    checkOutput("err_o", err, expErr);
    if (!skipHigh) checkOutput("clk_out_rise_half", clkOut, (mHi >= 1));
    @(negedge clk);
    #1;
    checkOutput("clk_out_fall_half", clkOut, (mHi >= 2));
  endtask

  task automatic runCycles(input int n, input logic en);
    for (int i = 0; i < n; i++) applyStimulus(en, 1'b0, 8'd0, 1'b1);
  endtask

  task automatic runUntilCnt(input int k);
    int budget = 64;
    while (nextCnt() != k && budget > 0) begin
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
      budget--;
    end
    checks++;
    assert (nextCnt() == k) else begin
      errors++;
      $error("[TB] FAIL runUntilCnt: reached cnt %0d expected %0d", nextCnt(), k);
    end
  endtask

  initial begin
    rstN = 1'b0; enI = 1'b0; loadI = 1'b0; divI = 8'd0;

    // Reset, then default ratio 7 running from reset
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    runCycles(21, 1'b1);

    // Mid-period load of 4 at cnt=2
    runUntilCnt(2);
    applyStimulus(1'b1, 1'b1, 8'd4, 1'b1);
    runCycles(16, 1'b1);

    // Back-to-back loads, last one wins with a single ack
    runUntilCnt(0);
    applyStimulus(1'b1, 1'b1, 8'd5, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'd9, 1'b1);
    runCycles(30, 1'b1);

    // Rejected ratios
    applyStimulus(1'b1, 1'b1, 8'd1, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'd0, 1'b1);
    runCycles(20, 1'b1);

    // Ratio 6, then disable at cnt=1 and re-enable
    applyStimulus(1'b1, 1'b1, 8'd6, 1'b1);
    runCycles(12, 1'b1);
    runUntilCnt(1);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
    runCycles(12, 1'b0);
    runCycles(14, 1'b1);

    // Load while disabled applies immediately
    runCycles(12, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'd3, 1'b1);
    runCycles(2, 1'b0);
    runCycles(12, 1'b1);

    // Reset at cnt=3 while a load is pending
    applyStimulus(1'b1, 1'b1, 8'd7, 1'b1);
    runCycles(10, 1'b1);
    runUntilCnt(2);
    applyStimulus(1'b1, 1'b1, 8'd5, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    runCycles(20, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(9) != 0), ($urandom_range(7) == 0),
                    8'($urandom_range(15)), ($urandom_range(99) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
